// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared helpers for the dual-clock FIFO pointer controllers:
//               Gray/binary conversion, pointer width rule and the default
//               synchroniser depth used by both clock domains.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Widest pointer the conversion helpers handle; callers zero-extend in
    // and truncate out, which is exact for both conversions.
    localparam int c_MAX_W = 32;

    // Synchroniser depth shared by the read- and write-side controllers.
    localparam int c_SYNC_STAGES_DEFAULT = 2;

    // Pointers carry one extra wrap bit above the memory address.
    function automatic int ptr_width(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic logic [c_MAX_W-1:0] bin2gray(input logic [c_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [c_MAX_W-1:0] gray2bin(input logic [c_MAX_W-1:0] g);
        logic [c_MAX_W-1:0] b;
        b[c_MAX_W-1] = g[c_MAX_W-1];
        for (int i = c_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ptr_sync.sv
`default_nettype none
// ============================================================================
// Module      : ptr_sync
// Description : Multi-flop synchroniser for a Gray-coded pointer crossing
//               into the local clock domain. Async active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module ptr_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             r_clk,
    input  logic             r_rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q [STAGES];

    // Shift the foreign pointer through STAGES flops; only the last is used.
    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            r_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                r_q[i] <= r_q[i-1];
            end
        end
    end

    assign q = r_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/async_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : async_fifo_rd_ctrl
// Description : Read-side pointer controller of the dual-clock FIFO. Owns the
//               binary/Gray read pointer, synchronises the write Gray pointer
//               into r_clk and derives empty, almost_empty, fill level,
//               memory read strobe and a sticky underflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module async_fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W        = 3,
    parameter int SYNC_STAGES   = c_SYNC_STAGES_DEFAULT,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic              r_clk,
    input  logic              r_rst,
    input  logic              r_inc,
    input  logic              uf_clr,
    input  logic [ADDR_W:0]   wr_ptr,
    output logic [ADDR_W:0]   rd_ptr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   rd_level,
    output logic              underflow
);

    localparam int                PTR_W     = ptr_width(ADDR_W);
    localparam logic [PTR_W-1:0]  c_AEMPTY  = PTR_W'(AEMPTY_THRESH);

    logic [PTR_W-1:0] r_rd_bin;
    logic [PTR_W-1:0] r_rd_gray;
    logic             r_underflow;
    logic [PTR_W-1:0] w_wr_gray_s;
    logic [PTR_W-1:0] w_wr_bin_s;
    logic [PTR_W-1:0] w_rd_bin_next;
    logic             w_empty;
    logic             w_do_pop;

    // Bring the write-domain Gray pointer into r_clk.
    ptr_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_wr_sync (
        .r_clk (r_clk),
        .r_rst (r_rst),
        .d     (wr_ptr),
        .q     (w_wr_gray_s)
    );

    // Only the synchronised value is decoded; the raw wr_ptr may be mid-change.
    assign w_wr_bin_s    = PTR_W'(gray2bin(c_MAX_W'(w_wr_gray_s)));
    assign w_empty       = (r_rd_gray == w_wr_gray_s);
    assign w_do_pop      = r_inc & ~w_empty;
    assign w_rd_bin_next = r_rd_bin + {{ADDR_W{1'b0}}, w_do_pop};

    // Advance binary and Gray read pointers together so they never disagree.
    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            r_rd_bin  <= '0;
            r_rd_gray <= '0;
        end else begin
            r_rd_bin  <= w_rd_bin_next;
            r_rd_gray <= PTR_W'(bin2gray(c_MAX_W'(w_rd_bin_next)));
        end
    end

    // Sticky underflow: a pop on empty wins over a same-cycle clear.
    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            r_underflow <= 1'b0;
        end else if (r_inc & w_empty) begin
            r_underflow <= 1'b1;
        end else if (uf_clr) begin
            r_underflow <= 1'b0;
        end
    end

    // Level lags real occupancy by in-flight writes, so it never over-reports.
    assign rd_level     = w_wr_bin_s - r_rd_bin;
    assign almost_empty = (rd_level <= c_AEMPTY);
    assign empty        = w_empty;
    assign rd_en        = w_do_pop;
    assign rd_ptr       = r_rd_gray;
    assign rd_addr      = r_rd_bin[ADDR_W-1:0];
    assign underflow    = r_underflow;

endmodule
`default_nettype wire
